pic_rw_control: RTL

Read/write control and initialisation sequencer for the 8259A-compatible PIC. It decodes the CPU strobes (CS_n, RD_n, WR_n, A0) and drives RD_flag/WR_flag to the data bus buffer. It captures the bytes the buffer forwards on Ds_to_W_R and sequences ICW1..ICW4 before accepting OCW1..OCW3. It publishes the decoded configuration and commands to the interrupt priority and control logic, and selects the source for CPU reads.

---
 rtl/pic_rw_control.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/pic_rw_control.sv
// Read/write strobe decode and ICW/OCW sequencing for an 8259A-compatible PIC.
// Bytes written by the CPU are latched while the write strobe is active and
// decoded on the edge where the write ends. The decoded configuration and
// commands are published as registered outputs.
//
// state     | meaning
// ----------+------------------------------------------------
// UNINIT    | after reset, only ICW1 is accepted
// WAIT_ICW2 | ICW1 seen, next A0=1 byte is the vector base
// WAIT_ICW3 | cascade mode, next A0=1 byte is the cascade config
// WAIT_ICW4 | ICW4 requested, next A0=1 byte is ICW4
// READY     | initialised, OCW1..OCW3 accepted
module pic_rw_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       CS_n,
  input  logic       RD_n,
  input  logic       WR_n,
  input  logic       A0,
  input  logic [7:0] Ds_to_W_R,
  output logic       RD_flag,
  output logic       WR_flag,
  output logic       init_done,
  output logic       ltim,
  output logic       sngl,
  output logic [4:0] vector_base,
  output logic [7:0] icw3,
  output logic       aeoi,
  output logic       upm,
  output logic [7:0] imr,
  output logic       ocw2_valid,
  output logic [2:0] ocw2_cmd,
  output logic [2:0] ocw2_level,
  output logic       smm,
  output logic [1:0] rd_src
);

  typedef enum logic [2:0] {
    UNINIT    = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } state_t;

  state_t     state, state_nx;
  logic       rd_act, wr_act;
  logic       commit, poll_consume;
  logic [7:0] wr_data;
  logic       wr_a0;
  logic       ic4, ic4_nx;
  logic       poll_req, poll_req_nx;
  logic       rr_sel, rr_sel_nx;
  logic       init_done_nx, ltim_nx, sngl_nx, aeoi_nx, upm_nx, smm_nx;
  logic       ocw2_valid_nx;
  logic [4:0] vector_base_nx;
  logic [7:0] icw3_nx, imr_nx;
  logic [2:0] ocw2_cmd_nx, ocw2_level_nx;

  // Both strobes low together is treated as no access at all.
  assign rd_act = ~CS_n & ~RD_n & WR_n;
  assign wr_act = ~CS_n & ~WR_n & RD_n;

  // The registered flags double as "previous edge" history for end-of-cycle detection.
  assign commit       = WR_flag & ~wr_act;
  assign poll_consume = RD_flag & ~rd_act;

  // Read source: a pending poll overrides everything, then the IMR address.
  assign rd_src = poll_req ? 2'd3 : (A0 ? 2'd2 : {1'b0, rr_sel});

  // Strobe flags and write capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RD_flag <= 1'b0;
      WR_flag <= 1'b0;
      wr_data <= 8'h00;
      wr_a0   <= 1'b0;
    end else begin
      RD_flag <= rd_act;
      WR_flag <= wr_act;
      if (wr_act) begin
        wr_data <= Ds_to_W_R;
        wr_a0   <= A0;
      end
    end
  end

  // State and configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= UNINIT;
      ic4         <= 1'b0;
      poll_req    <= 1'b0;
      rr_sel      <= 1'b0;
      init_done   <= 1'b0;
      ltim        <= 1'b0;
      sngl        <= 1'b0;
      vector_base <= 5'd0;
      icw3        <= 8'h00;
      aeoi        <= 1'b0;
      upm         <= 1'b0;
      imr         <= 8'h00;
      ocw2_valid  <= 1'b0;
      ocw2_cmd    <= 3'd0;
      ocw2_level  <= 3'd0;
      smm         <= 1'b0;
    end else begin
      state       <= state_nx;
      ic4         <= ic4_nx;
      poll_req    <= poll_req_nx;
      rr_sel      <= rr_sel_nx;
      init_done   <= init_done_nx;
      ltim        <= ltim_nx;
      sngl        <= sngl_nx;
      vector_base <= vector_base_nx;
      icw3        <= icw3_nx;
      aeoi        <= aeoi_nx;
      upm         <= upm_nx;
      imr         <= imr_nx;
      ocw2_valid  <= ocw2_valid_nx;
      ocw2_cmd    <= ocw2_cmd_nx;
      ocw2_level  <= ocw2_level_nx;
      smm         <= smm_nx;
    end
  end

  // Next-state decode of the committed byte; ICW1 is checked first so it wins everywhere.
  always_comb begin
    state_nx       = state;
    ic4_nx         = ic4;
    poll_req_nx    = poll_consume ? 1'b0 : poll_req;
    rr_sel_nx      = rr_sel;
    init_done_nx   = init_done;
    ltim_nx        = ltim;
    sngl_nx        = sngl;
    vector_base_nx = vector_base;
    icw3_nx        = icw3;
    aeoi_nx        = aeoi;
    upm_nx         = upm;
    imr_nx         = imr;
    ocw2_valid_nx  = 1'b0;
    ocw2_cmd_nx    = ocw2_cmd;
    ocw2_level_nx  = ocw2_level;
    smm_nx         = smm;

    if (commit) begin
      if (!wr_a0 && wr_data[4]) begin
        ltim_nx      = wr_data[3];
        sngl_nx      = wr_data[1];
        ic4_nx       = wr_data[0];
        imr_nx       = 8'h00;
        smm_nx       = 1'b0;
        aeoi_nx      = 1'b0;
        upm_nx       = 1'b0;
        poll_req_nx  = 1'b0;
        rr_sel_nx    = 1'b0;
        init_done_nx = 1'b0;
        state_nx     = WAIT_ICW2;
      end else begin
        case (state)
          WAIT_ICW2: begin
            if (wr_a0) begin
              vector_base_nx = wr_data[7:3];
              if (!sngl) begin
                state_nx = WAIT_ICW3;
              end else if (ic4) begin
                state_nx = WAIT_ICW4;
              end else begin
                state_nx     = READY;
                init_done_nx = 1'b1;
              end
            end
          end
          WAIT_ICW3: begin
            if (wr_a0) begin
              icw3_nx = wr_data;
              if (ic4) begin
                state_nx = WAIT_ICW4;
              end else begin
                state_nx     = READY;
                init_done_nx = 1'b1;
              end
            end
          end
          WAIT_ICW4: begin
            if (wr_a0) begin
              aeoi_nx      = wr_data[1];
              upm_nx       = wr_data[0];
              state_nx     = READY;
              init_done_nx = 1'b1;
            end
          end
          READY: begin
            if (wr_a0) begin
              imr_nx = wr_data;
            end else if (!wr_data[3]) begin
              ocw2_cmd_nx   = wr_data[7:5];
              ocw2_level_nx = wr_data[2:0];
              ocw2_valid_nx = 1'b1;
            end else begin
              if (wr_data[6]) smm_nx = wr_data[5];
              if (wr_data[1]) rr_sel_nx = wr_data[0];
              if (wr_data[2]) poll_req_nx = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
